// File: rtl/pwm_compare_dt_pkg.sv
// ============================================================================
//  Module      : pwm_compare_dt_pkg
//  Description : Shared widths and the deadtime FSM state type for the
//                compare / deadtime PWM gate driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif
`ifndef DT_WIDTH
`define DT_WIDTH 10
`endif

package pwm_compare_dt_pkg;

    localparam int PWMCOUNT_WIDTH = `PWMCOUNT_WIDTH;
    localparam int DT_WIDTH       = `DT_WIDTH;

    // Gate-driver states: both gates low in OFF and in the two DT states.
    typedef enum logic [2:0] {
        OFF     = 3'd0,
        DT_TO_H = 3'd1,
        H_ON    = 3'd2,
        DT_TO_L = 3'd3,
        L_ON    = 3'd4
    } dt_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_compare_dt_if.sv
// ============================================================================
//  Module      : pwm_compare_dt_if
//  Description : Carrier / register inputs and gate outputs of the
//                compare / deadtime PWM block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_compare_dt_if
    import pwm_compare_dt_pkg::*;
#(
    parameter int CNT_W = PWMCOUNT_WIDTH,
    parameter int DT_W  = DT_WIDTH
) ();

    logic [CNT_W-1:0] carrier;
    logic             maskevent;
    logic [CNT_W-1:0] compare;
    logic [DT_W-1:0]  deadtime;
    logic             pwm_onoff;
    logic             pwm_h;
    logic             pwm_l;
    logic             dt_active;

    // Side that supplies carrier and register values and watches the gates.
    modport master (
        output carrier, maskevent, compare, deadtime, pwm_onoff,
        input  pwm_h, pwm_l, dt_active
    );

    // The gate-driver block itself.
    modport slave (
        input  carrier, maskevent, compare, deadtime, pwm_onoff,
        output pwm_h, pwm_l, dt_active
    );

endinterface

`default_nettype wire

// File: rtl/deadtime_gen.sv
// ============================================================================
//  Module      : deadtime_gen
//  Description : Deadtime down-counter. Loads the interval length, counts
//                down while requested and flags the last deadtime cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deadtime_gen
    import pwm_compare_dt_pkg::*;
#(
    parameter int DT_W = DT_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            load,
    input  wire logic [DT_W-1:0] load_val,
    input  wire logic            dec,
    output logic      [DT_W-1:0] cnt,
    output logic                 done
);

    logic [DT_W-1:0] cnt_q;
    logic [DT_W-1:0] cnt_d;

    // Next count: load wins; decrement only from 2 upward so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q >= DT_W'(2))) begin
            cnt_d = cnt_q - DT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == DT_W'(1));

endmodule

`default_nettype wire

// File: rtl/pwm_compare_dt.sv
// ============================================================================
//  Module      : pwm_compare_dt
//  Description : Compares the carrier against a shadowed duty value and
//                drives complementary high/low gates with deadtime inserted
//                at every hand-over. Short comparator glitches that reverse
//                inside a deadtime interval fall back to the gate that was on.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_compare_dt
    import pwm_compare_dt_pkg::*;
#(
    parameter int CNT_W = PWMCOUNT_WIDTH,
    parameter int DT_W  = DT_WIDTH
) (
    input  wire logic clk,
    input  wire logic reset,
    pwm_compare_dt_if.slave pwm
);

    dt_state_t        state_q,     state_d;
    logic [CNT_W-1:0] cmp_sh_q,    cmp_sh_d;
    logic [DT_W-1:0]  dt_sh_q,     dt_sh_d;
    logic             raw_q,       raw_d;
    logic             pwm_h_q,     pwm_h_d;
    logic             pwm_l_q,     pwm_l_d;
    logic             dt_active_q, dt_active_d;

    logic             dt_load;
    logic             dt_dec;
    logic             dt_done;
    logic [DT_W-1:0]  dt_cnt;
    logic             dt_zero;

    assign dt_zero = (dt_sh_q == '0);

    // Shadow registers track the live registers at maskevent and while idle;
    // the comparator works against the shadow, one cycle of latency.
    always_comb begin
        cmp_sh_d = cmp_sh_q;
        dt_sh_d  = dt_sh_q;
        if (pwm.maskevent || (state_q == OFF)) begin
            cmp_sh_d = pwm.compare;
            dt_sh_d  = pwm.deadtime;
        end
        raw_d = (pwm.carrier < cmp_sh_q);
    end

    // Next state and counter control; outputs are decodes of the next state.
    always_comb begin
        state_d = state_q;
        dt_load = 1'b0;
        dt_dec  = 1'b0;
        if (!pwm.pwm_onoff) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF: begin
                    if (raw_q) begin
                        state_d = dt_zero ? H_ON : DT_TO_H;
                    end else begin
                        state_d = dt_zero ? L_ON : DT_TO_L;
                    end
                    dt_load = !dt_zero;
                end
                L_ON: begin
                    if (raw_q) begin
                        state_d = dt_zero ? H_ON : DT_TO_H;
                        dt_load = !dt_zero;
                    end
                end
                H_ON: begin
                    if (!raw_q) begin
                        state_d = dt_zero ? L_ON : DT_TO_L;
                        dt_load = !dt_zero;
                    end
                end
                DT_TO_H: begin
                    if (!raw_q) begin
                        state_d = L_ON;
                    end else if (dt_done) begin
                        state_d = H_ON;
                    end else begin
                        dt_dec = 1'b1;
                    end
                end
                DT_TO_L: begin
                    if (raw_q) begin
                        state_d = H_ON;
                    end else if (dt_done) begin
                        state_d = L_ON;
                    end else begin
                        dt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = OFF;
                end
            endcase
        end
        pwm_h_d     = (state_d == H_ON);
        pwm_l_d     = (state_d == L_ON);
        dt_active_d = (state_d == DT_TO_H) || (state_d == DT_TO_L);
    end

    // State, shadow, comparator and gate registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= OFF;
            cmp_sh_q    <= '0;
            dt_sh_q     <= '0;
            raw_q       <= 1'b0;
            pwm_h_q     <= 1'b0;
            pwm_l_q     <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmp_sh_q    <= cmp_sh_d;
            dt_sh_q     <= dt_sh_d;
            raw_q       <= raw_d;
            pwm_h_q     <= pwm_h_d;
            pwm_l_q     <= pwm_l_d;
            dt_active_q <= dt_active_d;
        end
    end

    deadtime_gen #(
        .DT_W (DT_W)
    ) u_deadtime_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (dt_load),
        .load_val (dt_sh_q),
        .dec      (dt_dec),
        .cnt      (dt_cnt),
        .done     (dt_done)
    );

    assign pwm.pwm_h     = pwm_h_q;
    assign pwm.pwm_l     = pwm_l_q;
    assign pwm.dt_active = dt_active_q;

endmodule

`default_nettype wire

// File: doc/pwm_compare_dt.md
PWM_COMPARE_DT -- requirements
Module: pwm_compare_dt

Interface
REQ-001 Parameter CNT_W, default `PWMCOUNT_WIDTH (16), sets the carrier and compare width.
REQ-002 Parameter DT_W, default `DT_WIDTH (10), sets the deadtime width in clk cycles.
REQ-003 clk  in  1  single block clock; all logic SHALL be synchronous to it.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 carrier  in  CNT_W  carrier count from the carrier generator.
REQ-006 maskevent  in  1  one-cycle shadow-load strobe from the event counter.
REQ-007 compare  in  CNT_W  duty compare value (unmasked register).
REQ-008 deadtime  in  DT_W  deadtime in clk cycles (unmasked register).
REQ-009 pwm_onoff  in  1  _pwm_onoff; 1 enables switching.
REQ-010 pwm_h  out  1  high-side gate, active-high.
REQ-011 pwm_l  out  1  low-side gate, active-high.
REQ-012 dt_active  out  1  high while a deadtime interval is in progress.

Function
REQ-013 The block SHALL hold shadow registers cmp_sh and dt_sh.
  - Both load from compare/deadtime on the cycle maskevent=1.
  - Both load every cycle while the state is OFF.
REQ-014 raw_r SHALL be registered each cycle as (carrier < cmp_sh), one cycle of latency.
  - cmp_sh=0 gives raw_r=0 constantly.
  - cmp_sh greater than the carrier peak gives raw_r=1 constantly.
REQ-015 The FSM states SHALL be OFF, DT_TO_H, H_ON, DT_TO_L, L_ON.
REQ-016 Outputs SHALL be registered decodes of the state:
  - pwm_h=(H_ON)
  - pwm_l=(L_ON)
  - dt_active=(DT_TO_H or DT_TO_L)
REQ-017 pwm_onoff=0 in any state SHALL force OFF on the next edge, so both gates are low one cycle later.
REQ-018 OFF with pwm_onoff=1 SHALL leave OFF toward raw_r's level:
  - raw_r=1: go to DT_TO_H, or to H_ON if dt_sh=0.
  - raw_r=0: go to DT_TO_L, or to L_ON if dt_sh=0.
REQ-019 L_ON with raw_r=1 SHALL go to H_ON if dt_sh=0; otherwise it goes to DT_TO_H and loads dt_cnt=dt_sh.
REQ-020 H_ON with raw_r=0 SHALL go to L_ON if dt_sh=0; otherwise it goes to DT_TO_L and loads dt_cnt=dt_sh.
REQ-021 Transitions out of DT_TO_H:
  - raw_r=0: return to L_ON (glitch cancel) without completing the deadtime.
  - else dt_cnt=1: go to H_ON.
  - else: decrement dt_cnt.
REQ-022 DT_TO_L SHALL mirror DT_TO_H with the roles of H and L swapped.
REQ-023 Both gates SHALL be low for exactly dt_sh cycles between one gate falling and the other rising; pwm_h and pwm_l SHALL never be 1 together.
REQ-024 A dt_sh reload during a DT state SHALL NOT alter the running dt_cnt.
REQ-025 Total latency from carrier crossing cmp_sh to gate rise SHALL be 2+dt_sh cycles.
REQ-026 dt_cnt SHALL be DT_W bits and SHALL never wrap: it is only decremented while it is at least 2.

Reset
REQ-027 While reset=0, outputs and registers SHALL take these values:
  - state=OFF
  - pwm_h=0, pwm_l=0, dt_active=0
  - raw_r=0, dt_cnt=0
  - cmp_sh=0, dt_sh=0
REQ-028 Reset SHALL assert asynchronously and release synchronously to clk.
REQ-029 Reset mid-deadtime SHALL abandon the interval, and the gates SHALL stay low until pwm_onoff re-enables the block.

Structure
REQ-030 Package PKG_pwm SHALL gain the following:
  - enum _dt_state {OFF, DT_TO_H, H_ON, DT_TO_L, L_ON}
  - define `DT_WIDTH=10
REQ-031 The deadtime down-counter (load, decrement, done=cnt==1) SHALL be a sub-module deadtime_gen, instantiated once.
REQ-032 The FSM, shadow registers and comparator SHALL reside in pwm_compare_dt.

Verification
REQ-033 Sawtooth carrier 0..99, cmp=40, dt=5, pwm_onoff=1 -> pwm_h high while carrier<40 (2-cycle skew); both gates low for exactly 5 cycles at each edge; dt_active matches.
REQ-034 dt=0, cmp=50 -> pwm_h and pwm_l toggle in the same cycle; dt_active never asserts.
REQ-035 In H_ON with dt=8, raw_r drops and then rises again 3 cycles into DT_TO_L -> return to H_ON; pwm_l never asserts.
REQ-036 compare changes 40->70 mid-period without maskevent -> duty unchanged until the maskevent cycle, new duty from the next comparison.
REQ-037 pwm_onoff drops during DT_TO_H with dt_cnt=4 -> OFF next edge, gates 0; re-enable with raw_r=1, dt=5 -> 5 low cycles, then pwm_h=1.
REQ-038 reset=0 asserted asynchronously while in H_ON -> pwm_h=0 immediately; after release, outputs stay 0 until pwm_onoff=1.
